// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: register-level hazard tracking for an in-order pipeline.
// Keeps a per-register "pending write" bitmap, stalls decode on RAW/WAW
// hazards against that bitmap, and runs a two-state branch-flush FSM that
// squashes decode and bubbles execute for the branch cycle plus one more.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   issue_*             decode-stage instruction (valid, rs1, rs2, uses_rs2, rd, regwrite)
//   wb_valid, wb_rd     writeback port clearing a pending write
//   branch_taken        execute resolved a taken branch
//   stall_d             hold fetch/decode registers (combinational)
//   flush_d, flush_e    squash decode / bubble execute (combinational)
//   busy                per-register pending-write bitmap (registered)
//   pending_cnt         popcount of busy
//   stall_cycles        saturating count of stalled cycles

// One pending-write flag. A clear beats a set so that a writeback landing
// in the same cycle as a new write to the same register leaves it free.
module hazard_busy_cell (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic busy
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      busy <= 1'b0;
        else if (clr) busy <= 1'b0;
        else if (set) busy <= 1'b1;
    end
endmodule

module hazard_scoreboard #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_uses_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_regwrite,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        branch_taken,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic [31:0] busy,
    output logic [5:0]  pending_cnt,
    output logic [15:0] stall_cycles
);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]          state;
    logic                flush_active;
    logic                hazard_raw;
    logic                hazard_waw;
    logic                issue_fire;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    // ---------------- branch flush FSM ----------------
    // FLUSH lasts one cycle and ignores branch_taken; a branch in the FLUSH
    // cycle is already covered by the squash in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     state <= branch_taken ? FLUSH : RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign flush_active = branch_taken | (state == FLUSH);
    assign flush_d      = flush_active;
    assign flush_e      = flush_active;

    // ---------------- hazard detection ----------------
    // Uses the registered bitmap only, so a writeback releases a stall on
    // the following cycle rather than forwarding through in the same cycle.
    // busy[0] is constant 0, which makes x0 hazard-free without extra terms;
    // the explicit !=0 checks keep the intent readable.
    assign hazard_raw = issue_valid &
                        ((busy[issue_rs1] & (issue_rs1 != 5'd0)) |
                         (issue_uses_rs2 & busy[issue_rs2] & (issue_rs2 != 5'd0)));
    assign hazard_waw = issue_valid & issue_regwrite & (issue_rd != 5'd0) & busy[issue_rd];

    // A flush overrides any stall: the instruction being held is squashed.
    assign stall_d    = (hazard_raw | hazard_waw) & ~flush_active;
    assign issue_fire = issue_valid & ~stall_d & ~flush_active;

    // ---------------- busy bitmap ----------------
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_fire && issue_regwrite && issue_rd != 5'd0)
            set_vec[issue_rd] = 1'b1;
        if (wb_valid && wb_rd != 5'd0)
            clr_vec[wb_rd] = 1'b1;
    end

    assign busy[0] = 1'b0;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_cell
            hazard_busy_cell u_cell (
                .clk  (clk),
                .rst  (rst),
                .set  (set_vec[g]),
                .clr  (clr_vec[g]),
                .busy (busy[g])
            );
        end
    endgenerate

    // ---------------- pending count ----------------
    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < NUM_REGS; i++)
            pending_cnt = pending_cnt + {5'd0, busy[i]};
    end

    // ---------------- stall statistics ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall_d && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rs1 = '0;
    logic [4:0]  issue_rs2 = '0;
    logic        issue_uses_rs2 = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_regwrite = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        branch_taken = 1'b0;
    logic        stall_d, flush_d, flush_e;
    logic [31:0] busy;
    logic [5:0]  pending_cnt;
    logic [15:0] stall_cycles;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_uses_rs2(issue_uses_rs2), .issue_rd(issue_rd), .issue_regwrite(issue_regwrite),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .branch_taken(branch_taken),
        .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .busy(busy), .pending_cnt(pending_cnt), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        stall;
        bit        flush;
        bit [31:0] busy;
        int        cnt;
        int        stalls;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: a set of outstanding writes, a count of remaining
    // squash cycles after a branch, and a capped stall counter.
    bit [31:0] m_pend;
    int        m_flush_left;
    int        m_stalls;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the DUT presents its outputs every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall_d",      stall_d,      e.stall);
            chk("flush_d",      flush_d,      e.flush);
            chk("flush_e",      flush_e,      e.flush);
            chk("busy",         busy,         e.busy);
            chk("pending_cnt",  pending_cnt,  e.cnt);
            chk("stall_cycles", stall_cycles, e.stalls);
        end
    end

    task automatic step(input bit r, input bit iv, input int rs1, input int rs2, input bit u2,
                        input int rd, input bit rw, input bit wv, input int wrd, input bit bt);
        exp_t e;
        bit   raw, waw, st, fa, fire;
        int   cnt;
        @(posedge clk);
        #1;
        rst = r; issue_valid = iv; issue_rs1 = rs1[4:0]; issue_rs2 = rs2[4:0];
        issue_uses_rs2 = u2; issue_rd = rd[4:0]; issue_regwrite = rw;
        wb_valid = wv; wb_rd = wrd[4:0]; branch_taken = bt;
        if (r) begin
            m_pend = '0; m_flush_left = 0; m_stalls = 0;
        end
        fa  = bt || (m_flush_left > 0);
        raw = iv && ((rs1 != 0 && m_pend[rs1]) || (u2 && rs2 != 0 && m_pend[rs2]));
        waw = iv && rw && rd != 0 && m_pend[rd];
        st  = (raw || waw) && !fa;
        cnt = 0;
        for (int i = 0; i < 32; i++) cnt += m_pend[i];
        e.stall = st; e.flush = fa; e.busy = m_pend; e.cnt = cnt; e.stalls = m_stalls;
        exp_q.push_back(e);
        if (!r) begin
            fire = iv && !st && !fa;
            if (st && m_stalls < 65535) m_stalls++;
            if (fire && rw && rd != 0) m_pend[rd] = 1'b1;
            if (wv && wrd != 0) m_pend[wrd] = 1'b0;
            if (m_flush_left > 0) m_flush_left = 0;
            else if (bt) m_flush_left = 1;
        end
    endtask

    task automatic idle();                          step(0,0,0,0,0,0,0,0,0,0); endtask
    task automatic iss(input int rs1, input int rs2, input bit u2, input int rd, input bit rw);
        step(0,1,rs1,rs2,u2,rd,rw,0,0,0);
    endtask

    initial begin
        int r1, r2, rd, wr;
        m_pend = '0; m_flush_left = 0; m_stalls = 0;
        step(1,0,0,0,0,0,0,0,0,0);
        step(1,0,0,0,0,0,0,0,0,1);   // branch during reset still drives flush
        idle();

        // load-use
        iss(0,0,0,5,1);
        iss(5,0,0,9,1);
        iss(5,0,0,9,1);
        step(0,1,5,0,0,9,1,1,5,0);   // wb x5: still stalled this cycle
        iss(5,0,0,9,1);              // released
        step(0,0,0,0,0,0,0,1,9,0);

        // x0 handling
        iss(0,0,0,0,1);
        iss(0,0,1,0,0);
        idle();

        // WAW
        iss(0,0,0,7,1);
        iss(0,0,1,7,1);
        iss(0,0,1,7,1);
        step(0,1,0,0,1,7,1,1,7,0);
        iss(0,0,1,7,1);
        step(0,0,0,0,0,0,0,1,7,0);

        // branch over a RAW stall, with a concurrent writeback
        iss(0,0,0,10,1);
        iss(0,0,0,11,1);
        iss(10,0,0,0,0);
        step(0,1,10,0,0,0,0,1,11,1);
        step(0,1,10,0,0,0,0,0,0,1);  // branch ignored in FLUSH
        iss(10,0,0,0,0);
        step(0,0,0,0,0,0,0,1,10,0);

        // counters and simultaneous set/clear
        iss(0,0,0,3,1);
        iss(0,0,0,4,1);
        iss(0,0,0,6,1);
        step(0,1,0,0,0,8,1,1,3,0);
        idle();
        step(0,0,0,0,0,0,0,1,20,0);  // wb to a free register
        step(0,0,0,0,0,0,0,1,4,0);
        step(0,0,0,0,0,0,0,1,6,0);
        step(0,0,0,0,0,0,0,1,8,0);

        // stall counter saturation
        iss(0,0,0,7,1);
        for (int i = 0; i < 70000; i++) iss(7,0,0,1,1);
        step(0,0,0,0,0,0,0,1,7,0);
        idle();

        // reset mid-flush with busy = 0xF0
        for (int i = 4; i < 8; i++) iss(0,0,0,i,1);
        step(0,0,0,0,0,0,0,0,0,1);
        step(1,0,0,0,0,0,0,0,0,0);
        idle();
        iss(4,0,0,0,0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r1 = $urandom_range(0, 9); r2 = $urandom_range(0, 9);
            rd = $urandom_range(0, 9); wr = $urandom_range(0, 9);
            step(($urandom_range(0, 499) == 0), $urandom_range(0, 3) != 0, r1, r2,
                 $urandom_range(0, 1), rd, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, wr, $urandom_range(0, 15) == 0);
        end
        idle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) chk("drain", exp_q.size(), 0);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have the following ports, clock and reset first; the block has one clock, and reset is asynchronous and active-high:
- clk  in  1  sole clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  decode stage holds a valid instruction
- issue_rs1  in  5  source register 1 of the decode instruction
- issue_rs2  in  5  source register 2 of the decode instruction
- issue_uses_rs2  in  1  the decode instruction reads rs2 (R-type, store, branch)
- issue_rd  in  5  destination register of the decode instruction
- issue_regwrite  in  1  the decode instruction writes rd
- wb_valid  in  1  writeback stage is writing the register file this cycle
- wb_rd  in  5  writeback destination register
- branch_taken  in  1  the execute stage resolved a taken branch
- stall_d  out  1  hold the fetch and decode pipeline registers
- flush_d  out  1  squash the decode instruction (zero the D register)
- flush_e  out  1  insert a bubble into execute (clear the E control bits)
- busy  out  32  per-register pending-write bitmap
- pending_cnt  out  6  popcount of busy
- stall_cycles  out  16  saturating count of stall cycles

Function
REQ-002 Register x0 SHALL never be marked busy and SHALL never cause a stall, regardless of the rs1, rs2 or rd value.
REQ-003 hazard_raw SHALL equal issue_valid AND ((busy[rs1] AND rs1!=0) OR (issue_uses_rs2 AND busy[rs2] AND rs2!=0)).
REQ-004 hazard_waw SHALL equal issue_valid AND issue_regwrite AND rd!=0 AND busy[rd].
REQ-005 stall_d SHALL be combinational and SHALL equal (hazard_raw OR hazard_waw) AND NOT flush_active.
REQ-006 An instruction issues in a cycle when issue_valid=1, stall_d=0 and flush_active=0.
REQ-007 On the rising edge after an issue with issue_regwrite=1 and rd!=0, busy[rd] SHALL be 1.
REQ-008 On the rising edge after wb_valid=1 with wb_rd!=0, busy[wb_rd] SHALL be 0.
REQ-009 Clear and set in the same cycle:
- Different registers: both SHALL take effect.
- Same register: the issue is stalled by REQ-004, so the clear SHALL take effect.
REQ-010 stall_d SHALL use the registered busy value, so writeback to a register does not release a stall on that register until the following cycle.
REQ-011 The FSM SHALL have two states, RUN and FLUSH; reset state is RUN.
REQ-012 In RUN, branch_taken=1 SHALL move the FSM to FLUSH on the next edge; otherwise the FSM stays in RUN.
REQ-013 The FSM SHALL remain in FLUSH for exactly 1 cycle, then return to RUN; branch_taken SHALL be ignored while in FLUSH.
REQ-014 flush_active SHALL equal branch_taken OR (state==FLUSH).
REQ-015 flush_d and flush_e SHALL both equal flush_active.
REQ-016 While flush_active=1, no issue SHALL occur and busy SHALL not be set, but wb_valid clears SHALL still apply.
REQ-017 When branch_taken coincides with a hazard, flush SHALL win: stall_d=0 and flush_d=flush_e=1.
REQ-018 pending_cnt SHALL equal the popcount of the registered busy bitmap, range 0..31.
REQ-019 stall_cycles SHALL increment by 1 on each edge where stall_d=1 and SHALL saturate at 16'hFFFF (no wrap).
REQ-020 wb_valid with wb_rd not busy SHALL be harmless: no state change other than the bit remaining 0.

Reset
REQ-021 rst=1 SHALL asynchronously force all of the following:
- busy=0, pending_cnt=0, stall_cycles=0
- FSM state=RUN
- stall_d=0 and flush_d=flush_e=0, unless branch_taken=1 is driven combinationally
REQ-022 Reset asserted mid-stall or mid-flush SHALL discard all pending state; after release the block SHALL behave exactly as after power-up.

Verification
REQ-023 Load-use hazard:
- Stimulus: issue rd=5 with regwrite, then issue rs1=5.
- Required response: stall_d=1 and stall_cycles increments.
- After wb_valid with wb_rd=5: stall_d=0 one cycle later and busy[5]=0.
REQ-024 x0 handling:
- Issue rd=0 with regwrite: busy stays 0.
- Issue rs1=0, rs2=0 with uses_rs2: stall_d=0.
REQ-025 WAW hazard: busy[7]=1, then issue rd=7 with regwrite and rs1=rs2=0 -> stall_d=1 until writeback to x7 completes.
REQ-026 Branch over hazard:
- Stimulus: branch_taken=1 while a RAW stall is pending.
- Required response: stall_d=0, flush_d=flush_e=1 for 2 cycles, and busy unchanged apart from concurrent writebacks.
REQ-027 Counters and simultaneous events:
- Issue rd=3,4,6 in consecutive cycles -> pending_cnt=3.
- wb_rd=3 in the same cycle as issue rd=8 -> busy has bits 4,6,8 set.
- Hold a stall for 70000 cycles -> stall_cycles=16'hFFFF.
REQ-028 Reset mid-flush: assert rst during FLUSH with busy=32'h0000_00F0 -> busy=0, state=RUN and flush outputs 0 immediately.
